// File: rtl/wrap_event_if.sv
// wrap_event_if
// Bundles the signals between the wrap-event consumer and its surroundings.
//   en, done, thresh, ack : driven by the master (counter/control side)
//   req, wrap_cnt,
//   req_cnt, overrun      : driven by the slave (wrap_event_handler)
// M sets the width of the threshold and the wrap accumulator.
interface wrap_event_if #(parameter int M = 8);
    logic         en;
    logic         done;
    logic [M-1:0] thresh;
    logic         ack;
    logic         req;
    logic [M-1:0] wrap_cnt;
    logic [7:0]   req_cnt;
    logic         overrun;

    modport master (
        output en, done, thresh, ack,
        input  req, wrap_cnt, req_cnt, overrun
    );

    modport slave (
        input  en, done, thresh, ack,
        output req, wrap_cnt, req_cnt, overrun
    );
endinterface

// File: rtl/wrap_event_handler.sv
// wrap_event_handler
// Counts terminal-count pulses (done) from an upstream free-running counter
// and raises a level request every T wraps, T = thresh (0 treated as 1).
// The request is held until ack; a threshold hit while the request is still
// pending sets the sticky overrun flag instead of queueing a second request.
// Ports:
//   clk   - rising-edge clock
//   rstn  - synchronous active-low reset
//   bus   - wrap_event_if slave: en, done, thresh, ack in;
//           req, wrap_cnt, req_cnt, overrun out (all registered)
module wrap_event_handler #(
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rstn,
    wrap_event_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        REQ   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         req_q, req_d;
    logic [M-1:0] wrap_q, wrap_d;
    logic [7:0]   rcnt_q, rcnt_d;
    logic         ovr_q, ovr_d;

    logic [M-1:0] thr_eff;
    logic [M:0]   wrap_inc;
    logic         hit;
    logic [M-1:0] wrap_after_done;

    // Threshold is sampled live; zero behaves as one wrap per request.
    assign thr_eff  = (bus.thresh == '0) ? {{(M-1){1'b0}}, 1'b1} : bus.thresh;
    // One extra bit so the increment cannot alias when compared.
    assign wrap_inc = {1'b0, wrap_q} + {{M{1'b0}}, 1'b1};
    // >= also fires when thresh was lowered below the current count.
    assign hit      = bus.done && (wrap_inc >= {1'b0, thr_eff});
    assign wrap_after_done = hit ? '0 : wrap_inc[M-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            wrap_q  <= '0;
            rcnt_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wrap_q  <= wrap_d;
            rcnt_q  <= rcnt_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wrap_d  = wrap_q;
        rcnt_d  = rcnt_q;
        ovr_d   = ovr_q;

        if (!bus.en) begin
            // Disable drops any pending request without acknowledging it.
            state_d = IDLE;
            req_d   = 1'b0;
            wrap_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    wrap_d  = '0;
                end
                COUNT: begin
                    if (bus.done) begin
                        wrap_d = wrap_after_done;
                        if (hit) begin
                            req_d   = 1'b1;
                            rcnt_d  = rcnt_q + 8'd1;
                            state_d = REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.done) begin
                        wrap_d = wrap_after_done;
                    end
                    if (bus.ack) begin
                        // An ack coinciding with a hit retires the old
                        // request and issues a fresh one in the same edge.
                        if (hit) begin
                            rcnt_d = rcnt_q + 8'd1;
                        end else begin
                            req_d   = 1'b0;
                            state_d = COUNT;
                        end
                    end else if (hit) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    wrap_d  = '0;
                end
            endcase
        end
    end

    assign bus.req      = req_q;
    assign bus.wrap_cnt = wrap_q;
    assign bus.req_cnt  = rcnt_q;
    assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_wrap_event_handler.sv
// tb_wrap_event_handler
// Directed stimulus for wrap_event_handler. A behavioural model tracks the
// expected outputs from the event rules (ack served first, then a done either
// issues a request or, if one is still outstanding, flags an overrun); a
// compare process checks every cycle after reset, and literal checks pin key
// points of each scenario.
module tb_wrap_event_handler;

    localparam int M = 8;

    logic clk;
    logic rstn;

    wrap_event_if #(.M(M)) bus ();

    wrap_event_handler #(.M(M)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    typedef struct {
        int req;
        int wrap;
        int rc;
        int ov;
        int live;   // enable was seen high at a previous edge since reset/disable
    } mstate_t;

    mstate_t m;
    bit      seen_rst;

    function automatic mstate_t model_next(mstate_t s, bit rn, bit e, bit d,
                                           bit a, int th);
        mstate_t n;
        int      t;
        n = s;
        t = (th == 0) ? 1 : th;
        if (!rn) begin
            n.req = 0; n.wrap = 0; n.rc = 0; n.ov = 0; n.live = 0;
            return n;
        end
        if (!e) begin
            n.req = 0; n.wrap = 0; n.live = 0;
            return n;
        end
        if (s.live == 0) begin
            n.live = 1;
            return n;
        end
        if (s.req != 0 && a) n.req = 0;
        if (d) begin
            if (s.wrap + 1 >= t) begin
                n.wrap = 0;
                if (n.req != 0) n.ov = 1;
                else begin
                    n.req = 1;
                    n.rc  = (s.rc + 1) % 256;
                end
            end else begin
                n.wrap = s.wrap + 1;
            end
        end
        return n;
    endfunction

    initial begin
        m.req = 0; m.wrap = 0; m.rc = 0; m.ov = 0; m.live = 0;
        seen_rst = 1'b0;
    end

    always @(posedge clk) begin
        if (!rstn) seen_rst <= 1'b1;
        m <= model_next(m, rstn, bus.en, bus.done, bus.ack, int'(bus.thresh));
    end

    always @(negedge clk) begin
        if (seen_rst) begin
            tests = tests + 4;
            if (int'(bus.req) != m.req) begin
                fails = fails + 1;
                $display("FAIL model_req t=%0t: got %0d expected %0d", $time, bus.req, m.req);
            end
            if (int'(bus.wrap_cnt) != m.wrap) begin
                fails = fails + 1;
                $display("FAIL model_wrap_cnt t=%0t: got %0d expected %0d", $time, bus.wrap_cnt, m.wrap);
            end
            if (int'(bus.req_cnt) != m.rc) begin
                fails = fails + 1;
                $display("FAIL model_req_cnt t=%0t: got %0d expected %0d", $time, bus.req_cnt, m.rc);
            end
            if (int'(bus.overrun) != m.ov) begin
                fails = fails + 1;
                $display("FAIL model_overrun t=%0t: got %0d expected %0d", $time, bus.overrun, m.ov);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int r, input int w,
                           input int rc, input int ov);
        chk({name, ".req"},      int'(bus.req),      r);
        chk({name, ".wrap_cnt"}, int'(bus.wrap_cnt), w);
        chk({name, ".req_cnt"},  int'(bus.req_cnt),  rc);
        chk({name, ".overrun"},  int'(bus.overrun),  ov);
    endtask

    // Drive inputs on the falling edge, return just after the next rising edge.
    task automatic tick(input logic e, input logic d, input logic a);
        @(negedge clk);
        bus.en   = e;
        bus.done = d;
        bus.ack  = a;
        @(posedge clk);
        #1;
    endtask

    // One wrap of a 3-bit upstream counter: seven quiet cycles then done.
    task automatic pulse_done();
        for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rstn       = 1'b0;
        bus.en     = 1'b0;
        bus.done   = 1'b0;
        bus.ack    = 1'b0;
        bus.thresh = 8'd3;

        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk_all("reset", 0, 0, 0, 0);
        rstn = 1'b1;

        // Basic cadence, thresh=3, ack two cycles after each request.
        tick(1'b1, 1'b0, 1'b0);
        pulse_done();
        chk("cadence.wrap1", int'(bus.wrap_cnt), 1);
        pulse_done();
        chk("cadence.wrap2", int'(bus.wrap_cnt), 2);
        pulse_done();
        chk_all("cadence.req1", 1, 0, 1, 0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("cadence.ack1", int'(bus.req), 0);
        for (int r = 2; r <= 3; r++) begin
            pulse_done();
            pulse_done();
            pulse_done();
            chk_all("cadence.reqn", 1, 0, r, 0);
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b1);
        end

        // Overrun with thresh=2 and no ack.
        bus.thresh = 8'd2;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk_all("ovr.req", 1, 0, 4, 0);
        tick(1'b1, 1'b1, 1'b0);
        chk_all("ovr.wrap1", 1, 1, 4, 0);
        tick(1'b1, 1'b1, 1'b0);
        chk_all("ovr.hit", 1, 0, 4, 1);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("ovr.ack", 0, 0, 4, 1);

        // Reset while a request is pending.
        bus.thresh = 8'd1;
        tick(1'b1, 1'b1, 1'b0);
        chk_all("midreq.req", 1, 0, 5, 1);
        rstn = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        chk_all("midreq.reset", 0, 0, 0, 0);
        rstn = 1'b1;
        tick(1'b1, 1'b0, 1'b0);

        // Simultaneous ack and done with thresh=1.
        tick(1'b1, 1'b1, 1'b0);
        chk_all("simul.req", 1, 0, 1, 0);
        tick(1'b1, 1'b1, 1'b1);
        chk_all("simul.both", 1, 0, 2, 0);
        tick(1'b1, 1'b0, 1'b1);
        chk("simul.ack", int'(bus.req), 0);

        // thresh=0 behaves as 1.
        bus.thresh = 8'd0;
        tick(1'b1, 1'b1, 1'b0);
        chk_all("thr0.req", 1, 0, 3, 0);
        tick(1'b1, 1'b0, 1'b1);

        // Lowering thresh below the accumulated count.
        bus.thresh = 8'd8;
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 1'b0);
        chk_all("lower.wrap5", 0, 5, 3, 0);
        bus.thresh = 8'd4;
        tick(1'b1, 1'b1, 1'b0);
        chk_all("lower.fire", 1, 0, 4, 0);

        // Enable drop during REQ with wrap_cnt=1.
        tick(1'b1, 1'b1, 1'b0);
        chk_all("endrop.pre", 1, 1, 4, 0);
        tick(1'b0, 1'b1, 1'b1);
        chk_all("endrop.drop", 0, 0, 4, 0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0);
        chk_all("endrop.idle", 0, 0, 4, 0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk_all("ack_outside_req", 0, 0, 4, 0);

        // req_cnt wraps modulo 256.
        bus.thresh = 8'd1;
        for (int i = 1; i <= 256; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (i == 252) chk("rcwrap.zero", int'(bus.req_cnt), 0);
            tick(1'b1, 1'b0, 1'b1);
        end
        chk("rcwrap.full", int'(bus.req_cnt), 4);

        tick(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
